// File: rtl/spi_engine_pkg.sv
//==============================================================================
// Module      : spi_engine_pkg
// Description : State encoding and divider legality check for spi_byte_engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package spi_engine_pkg;

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_SETUP  = 2'd1;
   localparam logic [1:0] c_ST_HOLD   = 2'd2;
   localparam logic [1:0] c_ST_FINISH = 2'd3;

   localparam int c_DIV_MAX = 15;

   function automatic logic div_is_legal(input int div, input int div_w);
      return (div >= 1) && (div <= c_DIV_MAX) && (div < (1 << div_w));
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_half_period.sv
//==============================================================================
// Module      : spi_half_period
// Description : SCK half-period counter; tick_o marks the last cycle of a phase.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_half_period #(
   parameter int DIV   = 2,
   parameter int DIV_W = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [DIV_W-1:0] c_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] c_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == c_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + c_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_byte_engine.sv
//==============================================================================
// Module      : spi_byte_engine
// Description : SPI mode-0 byte shifter: MSB-first TX on SCK/MOSI, parallel RX.
//               Define SPI_QUEUE_EN to add a one-byte holding register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_byte_engine
   import spi_engine_pkg::*;
#(
   parameter int DIV   = 2,
   parameter int DIV_W = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_stb_i,
   input  logic [7:0] wr_data_i,
   input  logic       miso_i,
   input  logic       clr_ovr_i,
   output logic       sck_o,
   output logic       mosi_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rx_data_o,
   output logic       overrun_o
);

   // An out-of-range divider falls back to the fastest legal rate.
   localparam logic c_DIV_OK  = div_is_legal(DIV, DIV_W);
   localparam int   c_DIV_EFF = c_DIV_OK ? DIV : 1;

   logic [1:0] state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       sck_q, sck_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ovr_q, ovr_d;
   logic       w_div_load;
   logic       w_div_en;
   logic       w_tick;
   logic       w_drop;
`ifdef SPI_QUEUE_EN
   logic [7:0] hold_q, hold_d;
   logic       hold_vld_q, hold_vld_d;
`endif

   spi_half_period #(
      .DIV   (c_DIV_EFF),
      .DIV_W (DIV_W)
   ) u_half_period (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (w_div_load),
      .en_i   (w_div_en),
      .tick_o (w_tick)
   );

   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rx_data_d  = rx_data_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      w_div_load = 1'b0;
      w_div_en   = 1'b0;
      w_drop     = 1'b0;
`ifdef SPI_QUEUE_EN
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      // During FINISH an empty holding register is bypassed: the byte starts directly.
      if (wr_stb_i && busy_q) begin
         if (hold_vld_q) begin
            w_drop = 1'b1;
         end else if (state_q != c_ST_FINISH) begin
            hold_d     = wr_data_i;
            hold_vld_d = 1'b1;
         end
      end
`else
      w_drop = wr_stb_i && busy_q;
`endif

      case (state_q)
         c_ST_IDLE: begin
            if (wr_stb_i) begin
               state_d    = c_ST_SETUP;
               tx_d       = wr_data_i;
               mosi_d     = wr_data_i[7];
               busy_d     = 1'b1;
               bit_d      = 3'd0;
               w_div_load = 1'b1;
            end
         end
         c_ST_SETUP: begin
            w_div_en = 1'b1;
            if (w_tick) begin
               state_d = c_ST_HOLD;
               sck_d   = 1'b1;
               rx_d    = {rx_q[6:0], miso_i};
            end
         end
         c_ST_HOLD: begin
            w_div_en = 1'b1;
            if (w_tick) begin
               sck_d = 1'b0;
               if (bit_q != 3'd7) begin
                  state_d = c_ST_SETUP;
                  bit_d   = bit_q + 3'd1;
                  tx_d    = {tx_q[6:0], tx_q[7]};
                  mosi_d  = tx_q[6];
               end else begin
                  state_d   = c_ST_FINISH;
                  rx_data_d = rx_q;
                  done_d    = 1'b1;
               end
            end
         end
         c_ST_FINISH: begin
`ifdef SPI_QUEUE_EN
            if (hold_vld_q) begin
               state_d    = c_ST_SETUP;
               tx_d       = hold_q;
               mosi_d     = hold_q[7];
               bit_d      = 3'd0;
               w_div_load = 1'b1;
               hold_vld_d = 1'b0;
            end else if (wr_stb_i) begin
               state_d    = c_ST_SETUP;
               tx_d       = wr_data_i;
               mosi_d     = wr_data_i[7];
               bit_d      = 3'd0;
               w_div_load = 1'b1;
            end else begin
               state_d = c_ST_IDLE;
               busy_d  = 1'b0;
            end
`else
            state_d = c_ST_IDLE;
            busy_d  = 1'b0;
`endif
         end
         default: begin
            state_d = c_ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // A new overrun takes priority over a coincident clear.
      if (w_drop) begin
         ovr_d = 1'b1;
      end else if (clr_ovr_i) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= c_ST_IDLE;
         bit_q      <= 3'd0;
         tx_q       <= 8'h00;
         rx_q       <= 8'h00;
         rx_data_q  <= 8'h00;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef SPI_QUEUE_EN
         hold_q     <= 8'h00;
         hold_vld_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rx_data_q  <= rx_data_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
`ifdef SPI_QUEUE_EN
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
`endif
      end
   end

   assign sck_o     = sck_q;
   assign mosi_o    = mosi_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rx_data_o = rx_data_q;
   assign overrun_o = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_engine.sv
//==============================================================================
// Module      : tb_spi_byte_engine
// Description : Self-checking bench for spi_byte_engine (DIV=2 and DIV=1 builds).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_byte_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, wr_stb, clr_ovr, miso, sel;
   logic [7:0] wr_data;
   logic       sck2, mosi2, busy2, done2, ovr2;
   logic [7:0] rx2;
   logic       sck1, mosi1, busy1, done1, ovr1;
   logic [7:0] rx1;

   spi_byte_engine #(.DIV(2), .DIV_W(4)) u_dut (
      .clk_i(clk), .rst_i(rst), .wr_stb_i(wr_stb), .wr_data_i(wr_data), .miso_i(miso),
      .clr_ovr_i(clr_ovr), .sck_o(sck2), .mosi_o(mosi2), .busy_o(busy2), .done_o(done2),
      .rx_data_o(rx2), .overrun_o(ovr2));

   spi_byte_engine #(.DIV(1), .DIV_W(4)) u_dut_div1 (
      .clk_i(clk), .rst_i(rst), .wr_stb_i(wr_stb), .wr_data_i(wr_data), .miso_i(miso),
      .clr_ovr_i(clr_ovr), .sck_o(sck1), .mosi_o(mosi1), .busy_o(busy1), .done_o(done1),
      .rx_data_o(rx1), .overrun_o(ovr1));

   logic       w_sck, w_mosi, w_busy, w_done, w_ovr;
   logic [7:0] w_rx;
   int         div_cur;
   always_comb begin
      w_sck   = sel ? sck1  : sck2;
      w_mosi  = sel ? mosi1 : mosi2;
      w_busy  = sel ? busy1 : busy2;
      w_done  = sel ? done1 : done2;
      w_ovr   = sel ? ovr1  : ovr2;
      w_rx    = sel ? rx1   : rx2;
      div_cur = sel ? 1 : 2;
   end

   // Bus monitor and mode-0 slave: slave shifts its byte out on each SCK fall.
   logic       mon_clr;
   logic [7:0] slave_byte, slave_sh, mosi_cap;
   logic [4:0] fall_cnt;
   logic       sck_prev, mosi_prev;
   int         rise_cnt, hi_len, lo_len, phase_err, mosi_err;

   always_comb begin
      slave_sh = slave_byte << fall_cnt[2:0];
      miso     = slave_sh[7];
   end

   always @(posedge clk) begin
      #1;
      if (mon_clr) begin
         rise_cnt = 0; fall_cnt = 5'd0; hi_len = 0; lo_len = 0;
         phase_err = 0; mosi_err = 0; mosi_cap = 8'h00;
      end else begin
         if (w_sck && !sck_prev) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[6:0], w_mosi};
            if ((rise_cnt % 8) != 1 && lo_len != div_cur) phase_err++;
            hi_len = 1;
         end else if (w_sck) begin
            hi_len++;
         end
         if (!w_sck && sck_prev) begin
            if (hi_len != div_cur) phase_err++;
            fall_cnt++;
            lo_len = 1;
         end else if (!w_sck) begin
            lo_len++;
         end
         if (w_sck && (w_mosi != mosi_prev)) mosi_err++;
      end
      sck_prev  = w_sck;
      mosi_prev = w_mosi;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Start byte b0, optionally strobe b1/b2 during cycles t1/t2; watch until BUSY drops.
   task automatic run(input logic [7:0] b0, input int t1, input logic [7:0] b1,
                      input int t2, input logic [7:0] b2,
                      output int n_done, output int done_cyc, output int end_cyc,
                      output logic [7:0] rx_at_done);
      bit fin;
      n_done = 0; done_cyc = 0; end_cyc = 0; rx_at_done = 8'h00; fin = 1'b0;
      @(negedge clk) mon_clr = 1'b1;
      @(negedge clk) begin mon_clr = 1'b0; wr_data = b0; wr_stb = 1'b1; end
      @(negedge clk) wr_stb = 1'b0;
      for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
         if (w_done) begin n_done++; done_cyc = cyc; rx_at_done = w_rx; end
         if (!w_busy) begin
            end_cyc = cyc;
            fin = 1'b1;
         end else begin
            wr_stb  = (cyc == t1) || (cyc == t2);
            wr_data = (cyc == t2) ? b2 : b1;
            @(negedge clk);
         end
      end
      wr_stb = 1'b0;
      chk("run_timeout", {31'd0, fin}, 32'd1);
      for (int k = 0; k < 200 && (busy1 || busy2); k++) @(negedge clk);
   endtask

   typedef struct {
      logic       sel;
      logic [7:0] tx;
      logic [7:0] slave;
      logic [7:0] exp_rx;
      int         exp_done;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd, dc, ec;
      logic [7:0] lrx;

      vecs[0] = '{1'b0, 8'hA5, 8'h3C, 8'h3C, 33};
      vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'h00, 17};
      vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 33};
      vecs[3] = '{1'b1, 8'h5A, 8'hC3, 8'hC3, 17};
      vecs[4] = '{1'b0, 8'h81, 8'h7E, 8'h7E, 33};

      rst = 1'b1; wr_stb = 1'b0; clr_ovr = 1'b0; wr_data = 8'h00; sel = 1'b0;
      mon_clr = 1'b1; slave_byte = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_sck", {31'd0, w_sck}, 32'd0);
      chk("reset_mosi", {31'd0, w_mosi}, 32'd0);
      chk("reset_busy", {31'd0, w_busy}, 32'd0);
      chk("reset_done", {31'd0, w_done}, 32'd0);
      chk("reset_rx", {24'd0, w_rx}, 32'h00);
      chk("reset_ovr", {31'd0, w_ovr}, 32'd0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         sel = vecs[i].sel;
         slave_byte = vecs[i].slave;
         run(vecs[i].tx, 0, 8'h00, 0, 8'h00, nd, dc, ec, lrx);
         chk($sformatf("v%0d_done_count", i), nd, 1);
         chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
         chk($sformatf("v%0d_busy_end", i), ec, vecs[i].exp_done + 1);
         chk($sformatf("v%0d_rx", i), {24'd0, lrx}, {24'd0, vecs[i].exp_rx});
         chk($sformatf("v%0d_mosi_bits", i), {24'd0, mosi_cap}, {24'd0, vecs[i].tx});
         chk($sformatf("v%0d_sck_rises", i), rise_cnt, 8);
         chk($sformatf("v%0d_phase_err", i), phase_err, 0);
         chk($sformatf("v%0d_mosi_while_high", i), mosi_err, 0);
         chk($sformatf("v%0d_mosi_idle", i), {31'd0, w_mosi}, {31'd0, vecs[i].tx[0]});
      end

      // Second strobe while busy.
      sel = 1'b0; slave_byte = 8'h3C;
      run(8'hC3, 5, 8'h11, 0, 8'h00, nd, dc, ec, lrx);
`ifdef SPI_QUEUE_EN
      chk("q_off_done_count", nd, 2);
      chk("q_off_rises", rise_cnt, 16);
      chk("q_off_ovr", {31'd0, w_ovr}, 32'd0);
      chk("q_off_last_byte", {24'd0, mosi_cap}, 32'h11);
`else
      chk("q_off_done_count", nd, 1);
      chk("q_off_rises", rise_cnt, 8);
      chk("q_off_ovr", {31'd0, w_ovr}, 32'd1);
      chk("q_off_last_byte", {24'd0, mosi_cap}, 32'hC3);
`endif
      @(negedge clk) clr_ovr = 1'b1;
      @(negedge clk) clr_ovr = 1'b0;
      chk("clr_ovr", {31'd0, w_ovr}, 32'd0);

      // Three strobes: start, one while busy, another while busy.
      run(8'h81, 3, 8'h42, 8, 8'h99, nd, dc, ec, lrx);
`ifdef SPI_QUEUE_EN
      chk("q_done_count", nd, 2);
      chk("q_done_cycle", dc, 66);
      chk("q_busy_end", ec, 67);
      chk("q_rises", rise_cnt, 16);
      chk("q_last_byte", {24'd0, mosi_cap}, 32'h42);
`else
      chk("q_done_count", nd, 1);
      chk("q_done_cycle", dc, 33);
      chk("q_busy_end", ec, 34);
      chk("q_rises", rise_cnt, 8);
      chk("q_last_byte", {24'd0, mosi_cap}, 32'h81);
`endif
      chk("q_rx", {24'd0, lrx}, 32'h3C);
      chk("q_phase_err", phase_err, 0);
      chk("q_ovr", {31'd0, w_ovr}, 32'd1);
      @(negedge clk) clr_ovr = 1'b1;
      @(negedge clk) clr_ovr = 1'b0;
      chk("q_clr_ovr", {31'd0, w_ovr}, 32'd0);

      // CLR_OVR coincident with a dropped strobe.
      @(negedge clk) begin wr_data = 8'h5A; wr_stb = 1'b1; end
      @(negedge clk) wr_stb = 1'b0;
      repeat (2) @(negedge clk);
`ifdef SPI_QUEUE_EN
      wr_data = 8'h66; wr_stb = 1'b1;
      @(negedge clk) wr_stb = 1'b0;
      @(negedge clk);
`endif
      wr_data = 8'h77; wr_stb = 1'b1; clr_ovr = 1'b1;
      @(negedge clk) begin wr_stb = 1'b0; clr_ovr = 1'b0; end
      chk("ovr_set_beats_clr", {31'd0, w_ovr}, 32'd1);
      for (int k = 0; k < 200 && (busy1 || busy2); k++) @(negedge clk);

      // Reset in the middle of a transfer.
      chk("pre_rst_rx", {24'd0, w_rx}, 32'h3C);
      @(negedge clk) mon_clr = 1'b1;
      @(negedge clk) begin mon_clr = 1'b0; wr_data = 8'hE7; wr_stb = 1'b1; end
      @(negedge clk) wr_stb = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("midrst_sck", {31'd0, w_sck}, 32'd0);
      chk("midrst_mosi", {31'd0, w_mosi}, 32'd0);
      chk("midrst_busy", {31'd0, w_busy}, 32'd0);
      chk("midrst_rx", {24'd0, w_rx}, 32'h00);
      chk("midrst_ovr", {31'd0, w_ovr}, 32'd0);
      begin
         int seen_done = 0;
         int seen_busy = 0;
         repeat (40) begin
            @(negedge clk);
            if (w_done) seen_done++;
            if (w_busy) seen_busy++;
         end
         chk("midrst_no_done", seen_done, 0);
         chk("midrst_stays_idle", seen_busy, 0);
      end
      slave_byte = 8'h96;
      run(8'hE7, 0, 8'h00, 0, 8'h00, nd, dc, ec, lrx);
      chk("post_rst_done_cycle", dc, 33);
      chk("post_rst_rx", {24'd0, lrx}, 32'h96);
      chk("post_rst_mosi_bits", {24'd0, mosi_cap}, 32'hE7);

      // WR_STB and RST in the same cycle.
      @(negedge clk) begin wr_data = 8'hFF; wr_stb = 1'b1; rst = 1'b1; end
      @(negedge clk) begin wr_stb = 1'b0; rst = 1'b0; end
      chk("stb_rst_busy", {31'd0, w_busy}, 32'd0);
      @(negedge clk);
      chk("stb_rst_busy_later", {31'd0, w_busy}, 32'd0);
      chk("stb_rst_sck", {31'd0, w_sck}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
